// File: rtl/palette_access_ctrl.sv
// Single-port scheduler for the 32x6 PPU palette RAM.
// Ports: clk/reset/ce; renderer lookup (render_en, render_addr, render_data);
// CPU port (cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ack, cpu_rdata);
// clear sweep (clear_start, clear_busy); RAM side (pal_addr, pal_din,
// pal_write, pal_dout).
module palette_access_ctrl #(
  parameter int         WQ_DEPTH    = 2,
  parameter logic [5:0] CLEAR_VALUE = 6'h0F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       render_en,
  input  logic [4:0] render_addr,
  output logic [5:0] render_data,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [5:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [5:0] cpu_rdata,
  input  logic       clear_start,
  output logic       clear_busy,
  output logic [4:0] pal_addr,
  output logic [5:0] pal_din,
  output logic       pal_write,
  input  logic [5:0] pal_dout
);

  localparam int AW = $clog2(WQ_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(WQ_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SWEEP = 2'd2;

  logic [1:0]    state;
  logic [4:0]    clr_cnt;
  logic [4:0]    q_addr [WQ_DEPTH];
  logic [5:0]    q_data [WQ_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic slot;
  logic q_empty;
  logic q_full;
  logic g_render;
  logic g_clear;
  logic g_qwr;
  logic g_read;
  logic push;
  logic pop;

  assign clear_busy = (state != S_IDLE);
  assign slot       = ce & ~reset;
  assign q_empty    = (count == '0);
  assign q_full     = (count == CNT_FULL);

  // Grants are mutually exclusive by construction.
  assign g_render = slot & render_en;
  assign g_clear  = slot & ~render_en & (state == S_SWEEP);
  assign g_qwr    = slot & ~render_en & (state != S_SWEEP) & ~q_empty;
  // Reads wait for an empty queue so they always see acked writes.
  // Gating on cpu_ack keeps a held request from being acked twice.
  assign g_read   = slot & ~render_en & ~clear_busy & q_empty
                  & cpu_req & ~cpu_we & ~cpu_ack;

  assign pop  = g_qwr;
  assign push = slot & cpu_req & cpu_we & ~cpu_ack & ~clear_busy
              & (~q_full | pop);

  always_comb begin
    pal_addr  = '0;
    pal_din   = '0;
    pal_write = 1'b0;
    unique case (1'b1)
      g_render: begin
        // Index 0 of every sub-palette shows the backdrop.
        pal_addr = (render_addr[1:0] == 2'b00) ? 5'd0 : render_addr;
      end
      g_clear: begin
        pal_addr  = clr_cnt;
        pal_din   = CLEAR_VALUE;
        pal_write = 1'b1;
      end
      g_qwr: begin
        pal_addr  = q_addr[head];
        pal_din   = q_data[head];
        pal_write = 1'b1;
      end
      g_read: begin
        pal_addr = cpu_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= cpu_addr;
      q_data[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      render_data <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      state       <= S_IDLE;
      clr_cnt     <= '0;
    end else begin
      cpu_ack <= push | g_read;
      if (g_render) render_data <= pal_dout;
      if (g_read)   cpu_rdata   <= pal_dout;
      if (push)     tail <= tail + 1'b1;
      if (pop)      head <= head + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      case (state)
        S_IDLE: begin
          if (clear_start) state <= S_WAIT;
        end
        S_WAIT: begin
          if (ce && q_empty) begin
            state   <= S_SWEEP;
            clr_cnt <= '0;
          end
        end
        S_SWEEP: begin
          if (g_clear) begin
            clr_cnt <= clr_cnt + 5'd1;
            if (clr_cnt == 5'd31) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palette_access_ctrl.sv
// Testbench for palette_access_ctrl: behavioural palette RAM plus a
// transaction-level reference model of the access rules.
module tb_palette_access_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       render_en;
  logic [4:0] render_addr;
  logic [5:0] render_data;
  logic       cpu_req;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [5:0] cpu_wdata;
  logic       cpu_ack;
  logic [5:0] cpu_rdata;
  logic       clear_start;
  logic       clear_busy;
  logic [4:0] pal_addr;
  logic [5:0] pal_din;
  logic       pal_write;
  logic [5:0] pal_dout;

  palette_access_ctrl dut (
    .clk(clk), .reset(reset), .ce(ce),
    .render_en(render_en), .render_addr(render_addr),
    .render_data(render_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .pal_addr(pal_addr), .pal_din(pal_din), .pal_write(pal_write),
    .pal_dout(pal_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] mir(input logic [4:0] a);
    return (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

  // Palette RAM environment: async read, $10 mirror.
  logic [5:0] pram [32];
  assign pal_dout = pram[mir(pal_addr)];
  always @(posedge clk)
    if (ce && pal_write) pram[mir(pal_addr)] <= pal_din;

  // Reference model state.
  typedef struct { logic [4:0] a; logic [5:0] d; } wq_t;
  wq_t        mq[$];
  logic [5:0] mram [32];
  int         m_phase;
  int         m_cnt;
  logic       m_ack;
  logic [5:0] m_rdata;
  logic [5:0] m_render;

  // {pal_write, pal_addr, pal_din, render_data, cpu_ack, cpu_rdata, busy}
  logic [25:0] exp_vec;
  logic [25:0] obs_vec;

  int vectors;
  int miscompares;

  task automatic step();
    logic       ew;
    logic [4:0] ea;
    logic [5:0] ed;
    logic [5:0] rv;
    bit         do_pop, do_push, do_rd, do_rend;
    int         qn;
    @(negedge clk);
    ew = 0; ea = '0; ed = '0; rv = '0;
    do_pop = 0; do_push = 0; do_rd = 0; do_rend = 0;
    qn = mq.size();
    if (!reset && ce) begin
      if (render_en) begin
        ea = (render_addr % 4 == 0) ? 5'd0 : render_addr;
        do_rend = 1;
      end else if (m_phase == 2) begin
        ew = 1; ea = 5'(m_cnt); ed = 6'h0F;
      end else if (qn > 0) begin
        ew = 1; ea = mq[0].a; ed = mq[0].d; do_pop = 1;
      end else if (cpu_req && !cpu_we && !m_ack && m_phase == 0) begin
        ea = cpu_addr; do_rd = 1;
      end
      rv = mram[mir(ea)];
      do_push = cpu_req && cpu_we && !m_ack && m_phase == 0
                && (qn < 2 || do_pop);
    end
    exp_vec[25:14] = {ew, ea, ed};
    obs_vec[25:14] = {pal_write, pal_addr, pal_din};
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_phase = 0; m_cnt = 0; m_ack = 0; m_rdata = '0; m_render = '0;
    end else begin
      if (ew) mram[mir(ea)] = ed;
      if (do_rend) m_render = rv;
      if (do_rd) m_rdata = rv;
      m_ack = do_push || do_rd;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{a: cpu_addr, d: cpu_wdata});
      if (m_phase == 0) begin
        if (clear_start) m_phase = 1;
      end else if (m_phase == 1) begin
        if (ce && qn == 0) begin m_phase = 2; m_cnt = 0; end
      end else if (ce && !render_en) begin
        if (m_cnt == 31) begin m_phase = 0; m_cnt = 0; end
        else m_cnt++;
      end
    end
    #1;
    exp_vec[13:0] = {m_render, m_ack, m_rdata, m_phase != 0};
    obs_vec[13:0] = {render_data, cpu_ack, cpu_rdata, clear_busy};
    // Requester drops its request once acked.
    if (cpu_ack) cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1; ce = 1; render_en = 1; render_addr = 5'($urandom);
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'h03; cpu_wdata = 6'h11;
    clear_start = 1;
    repeat (3) begin
      step(); vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset got=%h want=%h", obs_vec, exp_vec);
      end
    end
    vectors++;
    if ({clear_busy, pal_write, cpu_ack, render_data} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_outs got=%b%b%b%h want=0", clear_busy,
               pal_write, cpu_ack, render_data);
    end
    reset = 0; clear_start = 0; cpu_req = 0; render_en = 0;
  endtask

  task automatic test_render();
    logic [4:0] ra[$];
    logic [4:0] pa[3];
    ra = '{5'h04, 5'h05, 5'h1C};
    pa[0] = 5'd0; pa[1] = 5'd5; pa[2] = 5'd0;
    repeat (8) ra.push_back(5'($urandom));
    ce = 1; cpu_req = 0; render_en = 1;
    foreach (ra[i]) begin
      render_addr = ra[i];
      step(); vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL render[%0d] got=%h want=%h", i, obs_vec, exp_vec);
      end
      if (i < 3) begin
        vectors++;
        if (obs_vec[24:20] !== pa[i]) begin
          miscompares++;
          $display("FAIL render_addr[%0d] got=%h want=%h", i,
                   obs_vec[24:20], pa[i]);
        end
      end
    end
    render_en = 0;
  endtask

  typedef struct { bit we; logic [4:0] a; logic [5:0] d; } op_t;

  task automatic test_write_read();
    op_t        ops[4];
    logic [5:0] v;
    v = 6'($urandom);
    ops[0] = '{1'b1, 5'h11, 6'h2A};
    ops[1] = '{1'b0, 5'h11, 6'h00};
    ops[2] = '{1'b1, 5'h00, v};
    ops[3] = '{1'b0, 5'h10, 6'h00};
    ce = 1; render_en = 0;
    foreach (ops[i]) begin
      cpu_req = 1; cpu_we = ops[i].we;
      cpu_addr = ops[i].a; cpu_wdata = ops[i].d;
      for (int n = 0; n < 8 && cpu_req; n++) begin
        step(); vectors++;
        if (obs_vec !== exp_vec) begin
          miscompares++;
          $display("FAIL wr_rd[%0d] got=%h want=%h", i, obs_vec, exp_vec);
        end
      end
      vectors++;
      if (cpu_req) begin
        miscompares++;
        $display("FAIL wr_rd_timeout[%0d] got=no_ack want=ack", i);
        cpu_req = 0;
      end
      if (!ops[i].we) begin
        vectors++;
        if (cpu_rdata !== ((i == 1) ? 6'h2A : v)) begin
          miscompares++;
          $display("FAIL rdata[%0d] got=%h want=%h", i, cpu_rdata,
                   (i == 1) ? 6'h2A : v);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] wa[3];
    logic [5:0] wd[3];
    wa[0] = 5'h02; wa[1] = 5'h03; wa[2] = 5'h06;
    foreach (wd[i]) wd[i] = 6'($urandom);
    ce = 1; render_en = 1; render_addr = 5'h01;
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = wa[i]; cpu_wdata = wd[i];
      for (int n = 0; n < 4 && cpu_req; n++) begin
        step(); vectors++;
        if (obs_vec !== exp_vec) begin
          miscompares++;
          $display("FAIL b2b[%0d] got=%h want=%h", i, obs_vec, exp_vec);
        end
      end
      vectors++;
      if (cpu_req !== (i == 2)) begin
        miscompares++;
        $display("FAIL b2b_ack[%0d] got=pending%b want=pending%b", i,
                 cpu_req, i == 2);
      end
    end
    render_en = 0;
    repeat (3) begin
      step(); vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL b2b_drain got=%h want=%h", obs_vec, exp_vec);
      end
    end
    vectors++;
    if (cpu_req !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_third got=pending want=acked");
      cpu_req = 0;
    end
    step(); vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL b2b_last got=%h want=%h", obs_vec, exp_vec);
    end
    foreach (wa[i]) begin
      vectors++;
      if (pram[wa[i]] !== wd[i]) begin
        miscompares++;
        $display("FAIL b2b_ram[%0d] got=%h want=%h", i, pram[wa[i]], wd[i]);
      end
    end
  endtask

  task automatic test_clear();
    int k;
    ce = 1; render_en = 1; render_addr = 5'h05;
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'h07; cpu_wdata = 6'h15;
    step(); vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL clr_q got=%h want=%h", obs_vec, exp_vec);
    end
    cpu_req = 0;
    clear_start = 1;
    step(); vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL clr_start got=%h want=%h", obs_vec, exp_vec);
    end
    clear_start = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'h09; cpu_wdata = 6'h21;
    k = 0;
    for (int n = 0; n < 200 && cpu_req; n++) begin
      render_en = 1'($urandom);
      render_addr = 5'($urandom);
      step(); vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL clr[%0d] got=%h want=%h", n, obs_vec, exp_vec);
      end
      if (obs_vec[25] && k <= 32) begin
        vectors++;
        if (obs_vec[24:14] !== ((k == 0) ? {5'h07, 6'h15}
                                         : {5'(k - 1), 6'h0F})) begin
          miscompares++;
          $display("FAIL clr_order[%0d] got=%h", k, obs_vec[24:14]);
        end
        k++;
      end
    end
    vectors++;
    if (cpu_req || k != 33) begin
      miscompares++;
      $display("FAIL clr_done got=writes%0d pending%b want=writes33", k,
               cpu_req);
      cpu_req = 0;
    end
    render_en = 0;
    step(); vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL clr_tail got=%h want=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_reset_mid_clear();
    ce = 1; render_en = 0; cpu_req = 0; clear_start = 1;
    for (int n = 0; n < 60 && !(m_phase == 2 && m_cnt == 10); n++) begin
      step(); vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL rmc[%0d] got=%h want=%h", n, obs_vec, exp_vec);
      end
      clear_start = 0;
    end
    reset = 1;
    step(); vectors++;
    if (obs_vec !== exp_vec || clear_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmc_reset got=%h want=%h", obs_vec, exp_vec);
    end
    reset = 0;
    repeat (4) begin
      step(); vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL rmc_after got=%h want=%h", obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_ce_low();
    ce = 0; render_en = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0A; cpu_wdata = 6'($urandom);
    repeat (5) begin
      step(); vectors++;
      if (obs_vec !== exp_vec || cpu_req !== 1'b1) begin
        miscompares++;
        $display("FAIL ce_low got=%h want=%h", obs_vec, exp_vec);
      end
    end
    ce = 1;
    step(); vectors++;
    if (obs_vec !== exp_vec || cpu_req !== 1'b0) begin
      miscompares++;
      $display("FAIL ce_resume got=%h want=%h", obs_vec, exp_vec);
      cpu_req = 0;
    end
    repeat (2) begin
      step(); vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL ce_drain got=%h want=%h", obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      ce = ($urandom % 4) != 0;
      render_en = ($urandom % 3) == 0;
      render_addr = 5'($urandom);
      clear_start = ($urandom % 80) == 0;
      if (!cpu_req && ($urandom % 3) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom);
        cpu_addr = 5'($urandom); cpu_wdata = 6'($urandom);
      end
      step(); vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL rand[%0d] got=%h want=%h", n, obs_vec, exp_vec);
      end
    end
    clear_start = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1; ce = 0; render_en = 0; render_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    clear_start = 0;
    m_phase = 0; m_cnt = 0; m_ack = 0; m_rdata = '0; m_render = '0;
    for (int i = 0; i < 32; i++) begin
      pram[i] = 6'($urandom);
      mram[i] = pram[i];
    end
    test_reset();
    test_render();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_ce_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
